// File: rtl/tiny_cpu_uart_loader.sv
// UART program loader for the 16-byte tiny CPU: receives a framed image, writes it
// through the CPU load port and releases the CPU only after the checksum matches.
module tiny_cpu_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       prog_we,
  output logic [3:0] prog_addr,
  output logic [7:0] prog_data,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} fr_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  fr_state_e        fr_state_q, fr_state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [3:0]       index_q, index_d;
  logic [7:0]       sum_q, sum_d;
  logic [4:0]       remaining_q, remaining_d;
  logic             prog_we_d, cpu_rst_n_d, busy_d, done_d, err_d;
  logic [3:0]       prog_addr_d;
  logic [7:0]       prog_data_d;
  logic             count_ok_c, fr_error_c;

  // State and output registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= R_IDLE;
      fr_state_q   <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      index_q      <= '0;
      sum_q        <= '0;
      remaining_q  <= '0;
      prog_we      <= 1'b0;
      prog_addr    <= '0;
      prog_data    <= '0;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      fr_state_q   <= fr_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      index_q      <= index_d;
      sum_q        <= sum_d;
      remaining_q  <= remaining_d;
      prog_we      <= prog_we_d;
      prog_addr    <= prog_addr_d;
      prog_data    <= prog_data_d;
      cpu_rst_n    <= cpu_rst_n_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

  // RX next state
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (!rx_sync_q) rx_state_d = R_START;
      R_START: if (cnt_q == CNT_HALF) rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
      R_DATA:  if (cnt_q == CNT_LAST && bit_q == 3'd7) rx_state_d = R_STOP;
      R_STOP:  if (cnt_q == CNT_LAST) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  // RX datapath: bit timing, LSB-first shift, stop-bit outcome
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      R_START: if (cnt_q == CNT_HALF) cnt_d = '0;
      R_DATA: if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        shreg_d = {rx_sync_q, shreg_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      R_STOP: if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        byte_valid_d = rx_sync_q;
        frame_err_d  = !rx_sync_q;
      end
      default: cnt_d = '0;
    endcase
  end

  assign count_ok_c = (shreg_q[4:0] != 5'd0) && (shreg_q[4:0] <= 5'd16);
  // Any abort condition for an in-progress frame
  assign fr_error_c = (fr_state_q != IDLE) &&
                      (frame_err_q ||
                       (byte_valid_q && fr_state_q == COUNT && !count_ok_c) ||
                       (byte_valid_q && fr_state_q == CHECK && shreg_q != sum_q));

  // Frame next state
  always_comb begin
    fr_state_d = fr_state_q;
    if (fr_error_c) begin
      fr_state_d = IDLE;
    end else if (byte_valid_q) begin
      case (fr_state_q)
        IDLE:    if (shreg_q == HEADER) fr_state_d = COUNT;
        COUNT:   fr_state_d = DATA;
        DATA:    if (remaining_q == 5'd1) fr_state_d = CHECK;
        CHECK:   fr_state_d = IDLE;
        default: fr_state_d = IDLE;
      endcase
    end
  end

  // Frame outputs and bookkeeping
  always_comb begin
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr;
    prog_data_d = prog_data;
    cpu_rst_n_d = cpu_rst_n;
    busy_d      = busy;
    done_d      = done;
    err_d       = err;
    index_d     = index_q;
    sum_d       = sum_q;
    remaining_d = remaining_q;
    if (fr_error_c) begin
      err_d       = 1'b1;
      busy_d      = 1'b0;
      cpu_rst_n_d = 1'b0;
    end else if (byte_valid_q) begin
      case (fr_state_q)
        IDLE: if (shreg_q == HEADER) begin
          busy_d      = 1'b1;
          cpu_rst_n_d = 1'b0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          index_d     = '0;
          sum_d       = '0;
        end
        COUNT: remaining_d = shreg_q[4:0];
        DATA: begin
          prog_we_d   = 1'b1;
          prog_addr_d = index_q;
          prog_data_d = shreg_q;
          index_d     = index_q + 4'd1;
          sum_d       = sum_q + shreg_q;
          remaining_d = remaining_q - 5'd1;
        end
        CHECK: begin
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cpu_rst_n_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_cpu_uart_loader.sv
// Directed bench for tiny_cpu_uart_loader: UART frames in, load-port writes and status checked.
module tb_tiny_cpu_uart_loader;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       cpu_rst_n, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic       prev_we = 1'b0;

  tiny_cpu_uart_loader #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; strobes must never be back to back
  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      chk("we_single_cycle", 32'(prev_we), 32'(0));
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
    end
    prev_we = prog_we;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic send_glitch();
    rx = 1'b0;
    wait_clks(5);
    rx = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_cpu, input logic e_busy);
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'(done), 32'(e_done));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_cpu));
    chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic check_writes(input string tag, input logic [7:0] exp_d[$]);
    chk({tag, "_nwr"}, 32'(wr_data.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < wr_data.size()) begin
        chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
        chk({tag, "_data"}, 32'(wr_data[i]), 32'(exp_d[i]));
      end
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    logic [7:0] exp_d[$];
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clks(5);
    @(posedge clk); #1;
    chk("rst_we", 32'(prog_we), 32'(0));
    chk("rst_addr", 32'(prog_addr), 32'(0));
    chk("rst_data", 32'(prog_data), 32'(0));
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(4);

    // 1: basic three-byte load
    clear_writes();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
    wait_clks(4);
    check_status("t1", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_d = '{8'h12, 8'h34, 8'h56};
    check_writes("t1", exp_d);
    chk("t1_hold_addr", 32'(prog_addr), 32'(2));
    chk("t1_hold_data", 32'(prog_data), 32'(8'h56));

    // 2: bad checksum; header re-holds the CPU and clears done
    clear_writes();
    send_byte(8'hA5); send_byte(8'h03);
    check_status("t2_mid", 1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h00);
    wait_clks(4);
    check_status("t2", 1'b0, 1'b1, 1'b0, 1'b0);
    check_writes("t2", exp_d);

    // 3: count out of range, 0 and 17
    clear_writes();
    send_byte(8'hA5);
    check_status("t3a_hdr", 1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00);
    wait_clks(4);
    check_status("t3a", 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5);
    check_status("t3b_hdr", 1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h11);
    wait_clks(4);
    check_status("t3b", 1'b0, 1'b1, 1'b0, 1'b0);
    exp_d = {};
    check_writes("t3", exp_d);

    // 4: full 16-byte image
    clear_writes();
    exp_d = {};
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      exp_d.push_back(8'(i));
    end
    send_byte(8'h78);
    wait_clks(4);
    check_status("t4", 1'b1, 1'b0, 1'b1, 1'b0);
    check_writes("t4", exp_d);

    // 5: leading junk ignored, glitch after header produces no byte
    clear_writes();
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    check_status("t5_junk", 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    send_glitch();
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h07);
    wait_clks(4);
    check_status("t5", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_d = '{8'h07};
    check_writes("t5", exp_d);

    // 6: reset mid-frame, then a fresh load
    clear_writes();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    wait_clks(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_we", 32'(prog_we), 32'(0));
    chk("t6_rst_addr", 32'(prog_addr), 32'(0));
    chk("t6_rst_data", 32'(prog_data), 32'(0));
    chk("t6_rst_cpu_rst_n", 32'(cpu_rst_n), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_done", 32'(done), 32'(0));
    chk("t6_rst_err", 32'(err), 32'(0));
    wait_clks(3);
    exp_d = '{8'h11, 8'h22};
    check_writes("t6_pre", exp_d);
    rst_n = 1'b1;
    wait_clks(4);
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h65);
    wait_clks(4);
    check_status("t6", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_d = '{8'hAA, 8'hBB};
    check_writes("t6", exp_d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
